// File: rtl/uart_rx_ctrl_pkg.sv
// Shared constants for the UART receive controller: bus addresses, status
// word layout and controller state encoding.
package uart_rx_ctrl_pkg;

  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_REG_W      = 32;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  localparam logic [31:0] DEF_ADDR_RX_DATA = 32'h1001_0024;
  localparam logic [31:0] DEF_ADDR_RX_STAT = 32'h1001_0028;

  // Status word bit positions
  localparam int unsigned STAT_VALID   = 0;
  localparam int unsigned STAT_OVERRUN = 1;
  localparam int unsigned STAT_FULL    = 2;
  localparam int unsigned STAT_EMPTY   = 3;
  localparam int unsigned STAT_CNT_LSB = 4;
  localparam int unsigned STAT_CNT_W   = 4;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_LOAD = 2'd1,
    RX_HOLD = 2'd2
  } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Synchronous receive FIFO. A push into a full FIFO is accepted only when a
// pop frees a slot on the same edge; otherwise the byte is dropped.
module uart_rx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic [DATA_W-1:0]           wdata_i,
  input  logic                        pop_i,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage array; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller of the memory-mapped UART: buffers received bytes,
// sequences loads into the external Rx data register, reports status, raises
// an interrupt while a byte is held and tracks sticky overrun.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned REG_W        = DEF_REG_W,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter logic [31:0] ADDR_RX_DATA = DEF_ADDR_RX_DATA,
  parameter logic [31:0] ADDR_RX_STAT = DEF_ADDR_RX_STAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [31:0]       mem_addr,
  input  logic              mem_read,
  output logic              reg_enable,
  output logic [REG_W-1:0]  reg_d,
  output logic [REG_W-1:0]  rx_status,
  output logic              rx_irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  rx_state_e         state_q;
  logic              reg_enable_q;
  logic [REG_W-1:0]  reg_d_q;
  logic              rx_irq_q;
  logic              overrun_q, overrun_d;
  logic              rd_data_prev_q, rd_stat_prev_q;
  logic              rd_data_term, rd_stat_term;
  logic              rd_data_p, rd_stat_p;

  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;

  // Head is consumed during the LOAD cycle, when the register captures it
  assign fifo_pop = (state_q == RX_LOAD);

  uart_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (rx_done),
    .wdata_i (rx_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rd_data_term = mem_read & (mem_addr == ADDR_RX_DATA);
  assign rd_stat_term = mem_read & (mem_addr == ADDR_RX_STAT);
  assign rd_data_p    = rd_data_term & ~rd_data_prev_q;
  assign rd_stat_p    = rd_stat_term & ~rd_stat_prev_q;

  // Rising-edge detectors so a multi-cycle read acts once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_prev_q <= 1'b0;
      rd_stat_prev_q <= 1'b0;
    end else begin
      rd_data_prev_q <= rd_data_term;
      rd_stat_prev_q <= rd_stat_term;
    end
  end

  // Status read clears overrun, but a drop on the same edge keeps it set
  always_comb begin
    overrun_d = overrun_q & ~rd_stat_p;
    if (rx_done && fifo_full && !fifo_pop) overrun_d = 1'b1;
  end

  // Sticky overrun flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overrun_q <= 1'b0;
    else      overrun_q <= overrun_d;
  end

  // Load sequencer; outputs are registered so they line up with the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RX_IDLE;
      reg_enable_q <= 1'b0;
      reg_d_q      <= '0;
      rx_irq_q     <= 1'b0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          reg_enable_q <= 1'b0;
          reg_d_q      <= '0;
          rx_irq_q     <= 1'b0;
          if (!fifo_empty) begin
            state_q      <= RX_LOAD;
            reg_enable_q <= 1'b1;
            reg_d_q      <= REG_W'(fifo_head);
          end
        end
        RX_LOAD: begin
          state_q      <= RX_HOLD;
          reg_enable_q <= 1'b0;
          reg_d_q      <= '0;
          rx_irq_q     <= 1'b1;
        end
        RX_HOLD: begin
          if (rd_data_p) begin
            state_q  <= RX_IDLE;
            rx_irq_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= RX_IDLE;
          reg_enable_q <= 1'b0;
          reg_d_q      <= '0;
          rx_irq_q     <= 1'b0;
        end
      endcase
    end
  end

  assign reg_enable = reg_enable_q;
  assign reg_d      = reg_d_q;
  assign rx_irq     = rx_irq_q;

  // Status word assembly from live state
  always_comb begin
    rx_status                                  = '0;
    rx_status[STAT_VALID]                      = (state_q == RX_HOLD);
    rx_status[STAT_OVERRUN]                    = overrun_q;
    rx_status[STAT_FULL]                       = fifo_full;
    rx_status[STAT_EMPTY]                      = fifo_empty;
    rx_status[STAT_CNT_LSB +: STAT_CNT_W]      = STAT_CNT_W'(fifo_count);
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus a random
// phase, all compared against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam logic [31:0] A_DATA = 32'h1001_0024;
  localparam logic [31:0] A_STAT = 32'h1001_0028;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [31:0] mem_addr = '0;
  logic        mem_read = 1'b0;
  logic        reg_enable;
  logic [31:0] reg_d;
  logic [31:0] rx_status;
  logic        rx_irq;

  int checks = 0;
  int errors = 0;

  uart_rx_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .reg_enable (reg_enable),
    .reg_d      (reg_d),
    .rx_status  (rx_status),
    .rx_irq     (rx_irq)
  );

  always #5 clk = ~clk;

  // Reference model: queued bytes, whether a load is in progress, whether a
  // byte is waiting for the CPU, sticky overrun, previous read terms.
  logic [7:0] mq[$];
  bit m_loading, m_holding, m_ovr, m_prev_d, m_prev_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_loading = 0; m_holding = 0; m_ovr = 0; m_prev_d = 0; m_prev_s = 0;
  endtask

  task automatic model_edge();
    bit term_d, term_s, rd_d, rd_s, idle, nxt_load, nxt_hold;
    int pre_size;
    logic [7:0] popped;
    term_d   = mem_read && (mem_addr == A_DATA);
    term_s   = mem_read && (mem_addr == A_STAT);
    rd_d     = term_d && !m_prev_d;
    rd_s     = term_s && !m_prev_s;
    pre_size = mq.size();
    idle     = !m_loading && !m_holding;
    nxt_load = idle && (pre_size > 0);
    nxt_hold = m_holding && !rd_d;
    if (m_loading) begin
      popped   = mq.pop_front();
      nxt_hold = 1;
    end
    if (rd_s) m_ovr = 0;
    if (rx_done) begin
      if (mq.size() < DEPTH) mq.push_back(rx_data);
      else m_ovr = 1;
    end
    m_prev_d  = term_d;
    m_prev_s  = term_s;
    m_loading = nxt_load;
    m_holding = nxt_hold;
  endtask

  function automatic logic [31:0] exp_status();
    int n;
    n = mq.size();
    return {24'd0, 4'(n), (n == 0), (n == DEPTH), m_ovr, m_holding};
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".en"},   {31'd0, reg_enable}, {31'd0, m_loading});
    chk({tag, ".d"},    reg_d, m_loading ? {24'd0, mq[0]} : 32'd0);
    chk({tag, ".irq"},  {31'd0, rx_irq}, {31'd0, m_holding});
    chk({tag, ".stat"}, rx_status, exp_status());
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [7:0] b;
    int sel;
    model_reset();

    // Power-on reset
    #2;
    chk("rst0.en", {31'd0, reg_enable}, 32'd0);
    chk("rst0.irq", {31'd0, rx_irq}, 32'd0);
    chk("rst0.stat", rx_status, 32'h08);
    #10 rst = 1'b1;
    step("idle0");

    // Single byte latency
    rx_data = 8'hA5; rx_done = 1'b1;
    step("t2.push");
    rx_done = 1'b0;
    step("t2.load");
    chk("t2.en_n1", {31'd0, reg_enable}, 32'd1);
    chk("t2.d_n1", reg_d, 32'h0000_00A5);
    chk("t2.irq_n1", {31'd0, rx_irq}, 32'd0);
    step("t2.hold");
    chk("t2.irq_n2", {31'd0, rx_irq}, 32'd1);
    mem_addr = A_DATA; mem_read = 1'b1;
    step("t2.read");
    chk("t2.irq_clr", {31'd0, rx_irq}, 32'd0);
    mem_read = 1'b0;
    step("t2.idle");

    // Long read consumes once
    rx_data = 8'h11; rx_done = 1'b1;
    step("t3.p1");
    rx_data = 8'h22;
    step("t3.p2");
    rx_done = 1'b0;
    step("t3.h1");
    mem_addr = A_DATA; mem_read = 1'b1;
    step("t3.r1");
    step("t3.r2");
    chk("t3.d22", reg_d, 32'h0000_0022);
    step("t3.r3");
    mem_read = 1'b0;
    step("t3.after");
    chk("t3.still_held", {31'd0, rx_irq}, 32'd1);
    mem_read = 1'b1;
    step("t3.c");
    mem_read = 1'b0;
    step("t3.idle");

    // Overrun: six bytes back to back with no reads
    for (int i = 0; i < 6; i++) begin
      rx_data = 8'($urandom); rx_done = 1'b1;
      step("t4.push");
    end
    rx_done = 1'b0;
    step("t4.settle");
    chk("t4.stat", rx_status, 32'h47);
    mem_addr = A_STAT; mem_read = 1'b1;
    step("t4.rdstat");
    chk("t4.ovr_clr", rx_status, 32'h45);
    mem_read = 1'b0;
    step("t4.done");

    // Full FIFO: push coincides with the LOAD pop
    mem_addr = A_DATA; mem_read = 1'b1;
    step("t5.read");
    mem_read = 1'b0;
    step("t5.load");
    chk("t5.en", {31'd0, reg_enable}, 32'd1);
    chk("t5.full", rx_status, 32'h44);
    rx_data = 8'($urandom); rx_done = 1'b1;
    step("t5.pushpop");
    rx_done = 1'b0;
    chk("t5.noovr", rx_status, 32'h45);

    // Drain everything, then a data read while idle and empty
    for (int i = 0; i < 8; i++) begin
      mem_addr = A_DATA; mem_read = 1'b1;
      step("t6.drain_r");
      mem_read = 1'b0;
      step("t6.drain_a");
      step("t6.drain_b");
    end
    chk("t6.empty", rx_status, 32'h08);
    mem_read = 1'b1;
    step("t6.idle_read");
    chk("t6.no_en", {31'd0, reg_enable}, 32'd0);
    chk("t6.no_irq", {31'd0, rx_irq}, 32'd0);
    mem_read = 1'b0;
    step("t6.idle2");
    chk("t6.no_en2", {31'd0, reg_enable}, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rx_done  = ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom);
      mem_read = ($urandom_range(0, 2) == 0);
      sel      = $urandom_range(0, 3);
      mem_addr = (sel == 0) ? A_STAT : (sel == 3) ? 32'h1001_0020 : A_DATA;
      step("rnd");
    end
    rx_done = 1'b0; mem_read = 1'b0;
    step("rnd.end");

    // Reset in the middle of HOLD with two bytes queued
    rst = 1'b0; #3; rst = 1'b1; model_reset();
    step("t1.clean");
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom); rx_data = b; rx_done = 1'b1;
      step("t1.push");
    end
    rx_done = 1'b0;
    step("t1.hold");
    chk("t1.pre", rx_status, 32'h21);
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk("t1.en", {31'd0, reg_enable}, 32'd0);
    chk("t1.d", reg_d, 32'd0);
    chk("t1.irq", {31'd0, rx_irq}, 32'd0);
    chk("t1.stat", rx_status, 32'h08);
    #2 rst = 1'b1;
    step("t1.rel1");
    step("t1.rel2");
    chk("t1.idle", rx_status, 32'h08);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
